accum_req_arbiter: RTL
======================

Name: accum_req_arbiter

Overview:
- Shares the accumulator router's single slave port among NUM_REQ compute requesters (e.g. MAC lanes, Scloud/Frodo kernels).
- Write and read command channels are arbitrated independently, each with a round-robin arbiter.
- The router returns read data as a tag-less OR-mux, so this block keeps an in-order FIFO of requester IDs and steers each returned beat to the requester that issued the read.
- Sits directly upstream of the router. Read data returns in issue order across zones; this is a system guarantee.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- REQ_W, 2, requester index width, $clog2(NUM_REQ).
- ZONE_WIDTH, 2, zone id width.
- NUM_BANKS, 4, banks per zone; mask width.
- DATA_WIDTH, 64, bits per bank.
- ADDR_WIDTH, 8, accumulator row address width.
- MAX_OUTSTANDING, 8, depth of the read-tag FIFO; must be a power of two.
- Derived WR_W = ZONE_WIDTH+1+NUM_BANKS+ADDR_WIDTH+NUM_BANKS*DATA_WIDTH; packing is {zone_id, accum_en, mask, addr, wdata}, MSB first.
- Derived RD_W = ZONE_WIDTH+NUM_BANKS+ADDR_WIDTH; packing is {zone_id, mask, addr}.
- Derived RW = NUM_BANKS*DATA_WIDTH.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_wr_valid  in  NUM_REQ  per-requester write/accumulate command valid
- req_wr_ready  out  NUM_REQ  per-requester write ready
- req_wr_pld  in  NUM_REQ*WR_W  per-requester write payload, requester i at slice i
- req_rd_valid  in  NUM_REQ  per-requester read command valid
- req_rd_ready  out  NUM_REQ  per-requester read ready
- req_rd_pld  in  NUM_REQ*RD_W  per-requester read payload
- req_rvalid  out  NUM_REQ  read data valid, one-hot
- req_rdata  out  RW  read data, broadcast to all requesters
- m_wr_valid  out  1  write command valid to router; wvalid is tied to the same signal
- m_wr_ready  in  1  router write ready
- m_wr_pld  out  WR_W  granted write payload
- m_rd_valid  out  1  read command valid to router
- m_rd_ready  in  1  router read ready
- m_rd_pld  out  RD_W  granted read payload
- m_rvalid  in  1  router read data valid
- m_rdata  in  RW  router read data
- rd_outstanding  out  $clog2(MAX_OUTSTANDING)+1  reads issued but not yet returned
- err_orphan  out  1  sticky flag: rvalid arrived with no read outstanding

Behaviour:
- Reset values: all outputs 0; write and read round-robin pointers = 0; tag FIFO empty; err_orphan = 0. Reset asserted mid-transfer discards all in-flight tags and drops any pending grant; read data for those tags that arrives after reset sets err_orphan.
- Write arbiter has two states, IDLE and LOCKED.
  - IDLE: the grant goes to the first requester with valid asserted, searching from ptr_wr upward and wrapping modulo NUM_REQ.
  - m_wr_valid = req_wr_valid[g]; m_wr_pld = slice g.
  - req_wr_ready[g] = m_wr_ready; all other readies = 0.
  - A combinational valid-to-valid path is allowed; there is zero added latency.
- Write handshake (m_wr_valid && m_wr_ready):
  - the beat is accepted;
  - ptr_wr <= g+1 (mod NUM_REQ);
  - the state stays IDLE.
- Write stall (m_wr_valid && !m_wr_ready):
  - go to LOCKED and hold g until the handshake completes; higher-priority arrivals cannot preempt.
  - Requesters must not drop valid or change payload while stalled.
  - On handshake in LOCKED: ptr_wr <= g+1 and return to IDLE.
- Read arbiter: same IDLE/LOCKED structure with its own pointer ptr_rd.
  - m_rd_valid is additionally gated by !tag_full, where tag_full means rd_outstanding == MAX_OUTSTANDING.
  - While tag_full, m_rd_valid = 0 and all req_rd_ready = 0. A LOCKED grant is kept.
- Read handshake: push g into the tag FIFO.
- Read return: m_rvalid pops the FIFO head h; req_rvalid = one-hot(h) for that same cycle (combinational); req_rdata = m_rdata.
  - No rready exists; requesters must accept the beat.
- Simultaneous push and pop in one cycle: rd_outstanding is unchanged and both operations are valid. When the FIFO is full this frees no slot in that same cycle, because the gate uses the registered count.
- m_rvalid with the FIFO empty: the data is dropped, req_rvalid = 0, and err_orphan <= 1 until reset.
- Write and read channels are fully independent: both may hand off on the same cycle to the same or different requesters.
- Tag FIFO: MAX_OUTSTANDING entries, REQ_W bits each, with wrapping read and write pointers; the count is held in rd_outstanding.

Test Plan:
- Single requester write: req 2 writes zone 1, addr 0x10, mask 4'b1111, accum_en 1 with m_wr_ready = 1 -> same-cycle m_wr_valid = 1, m_wr_pld equals slice 2, req_wr_ready = 4'b0100, ptr_wr -> 3.
- Fairness: all 4 requesters hold write valid for 8 cycles with ready always 1 -> grant order 0,1,2,3,0,1,2,3.
- Back-pressure lock: req 1 granted, m_wr_ready = 0 for 3 cycles while req 0 raises valid -> grant stays 1 and the payload is stable; after the handshake the next grant is req 0 (wrap from pointer 2).
- Read ordering: reads from req 3, req 0, req 2 accepted, then 3 rvalid beats with data A, B, C -> req_rvalid = 4'b1000/A, then 4'b0001/B, then 4'b0100/C; rd_outstanding goes 3 -> 0.
- Full FIFO: 8 reads accepted with no returns -> m_rd_valid = 0 and rd_outstanding = 8. A simultaneous rvalid in that cycle does not reopen issue; issue resumes the next cycle.
- Orphan and reset: rvalid with the FIFO empty -> err_orphan = 1 and no req_rvalid. Assert rstn mid-stream with 3 reads outstanding -> all outputs 0 and count 0; a later rvalid sets err_orphan.

Source files
------------

// File: rtl/accum_req_arbiter.sv
// Round-robin arbitration of NUM_REQ requesters onto the accumulator router's
// single slave port, with an in-order tag FIFO that steers returned read beats.
module accum_req_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int REQ_W            = 2,
  parameter int ZONE_WIDTH       = 2,
  parameter int NUM_BANKS        = 4,
  parameter int DATA_WIDTH       = 64,
  parameter int ADDR_WIDTH       = 8,
  parameter int MAX_OUTSTANDING  = 8,
  localparam int WR_W  = ZONE_WIDTH + 1 + NUM_BANKS + ADDR_WIDTH + NUM_BANKS * DATA_WIDTH,
  localparam int RD_W  = ZONE_WIDTH + NUM_BANKS + ADDR_WIDTH,
  localparam int RW    = NUM_BANKS * DATA_WIDTH,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req_wr_valid,
  output logic [NUM_REQ-1:0]        req_wr_ready,
  input  logic [NUM_REQ*WR_W-1:0]   req_wr_pld,
  input  logic [NUM_REQ-1:0]        req_rd_valid,
  output logic [NUM_REQ-1:0]        req_rd_ready,
  input  logic [NUM_REQ*RD_W-1:0]   req_rd_pld,
  output logic [NUM_REQ-1:0]        req_rvalid,
  output logic [RW-1:0]             req_rdata,
  output logic                      m_wr_valid,
  input  logic                      m_wr_ready,
  output logic [WR_W-1:0]           m_wr_pld,
  output logic                      m_rd_valid,
  input  logic                      m_rd_ready,
  output logic [RD_W-1:0]           m_rd_pld,
  input  logic                      m_rvalid,
  input  logic [RW-1:0]             m_rdata,
  output logic [CNT_W-1:0]          rd_outstanding,
  output logic                      err_orphan
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  // Returns {found, index} of the first set bit at or after ptr, wrapping.
  function automatic logic [REQ_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [REQ_W-1:0]   ptr);
    logic [REQ_W:0]   res;
    logic [REQ_W-1:0] idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = REQ_W'((int'(ptr) + k) % NUM_REQ);
      if (valid[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [REQ_W-1:0] rr_next(input logic [REQ_W-1:0] g);
    return (g == REQ_W'(NUM_REQ - 1)) ? '0 : g + REQ_W'(1);
  endfunction

  logic [WR_W-1:0] wr_pld_arr [NUM_REQ];
  logic [RD_W-1:0] rd_pld_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign wr_pld_arr[gi] = req_wr_pld[gi*WR_W +: WR_W];
    assign rd_pld_arr[gi] = req_rd_pld[gi*RD_W +: RD_W];
  end

  arb_state_e       wr_state_q, wr_state_d, rd_state_q, rd_state_d;
  logic [REQ_W-1:0] ptr_wr_q, ptr_wr_d, ptr_rd_q, ptr_rd_d;
  logic [REQ_W-1:0] wr_grant_q, wr_grant_d, rd_grant_q, rd_grant_d;
  logic [REQ_W:0]   wr_pick, rd_pick;
  logic [REQ_W-1:0] wr_g, rd_g;
  logic             wr_any, rd_any;

  logic [REQ_W-1:0] tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] tag_wr_ptr_q, tag_rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_orphan_q;
  logic             tag_full, tag_push, tag_pop;

  assign tag_full = (count_q == CNT_W'(MAX_OUTSTANDING));

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    wr_pick    = rr_pick(req_wr_valid, ptr_wr_q);
    wr_any     = (wr_state_q == ARB_LOCKED) | wr_pick[REQ_W];
    wr_g       = (wr_state_q == ARB_LOCKED) ? wr_grant_q : wr_pick[REQ_W-1:0];
    m_wr_valid = wr_any & req_wr_valid[wr_g];
    m_wr_pld   = wr_pld_arr[wr_g];
    req_wr_ready       = '0;
    req_wr_ready[wr_g] = m_wr_valid & m_wr_ready;
    wr_state_d = wr_state_q;
    ptr_wr_d   = ptr_wr_q;
    wr_grant_d = wr_grant_q;
    if (m_wr_valid && m_wr_ready) begin
      wr_state_d = ARB_IDLE;
      ptr_wr_d   = rr_next(wr_g);
    end else if (m_wr_valid) begin
      wr_state_d = ARB_LOCKED;
      wr_grant_d = wr_g;
    end
  end

  // A full tag FIFO masks the read port but keeps any locked grant.
  always_comb begin
    rd_pick    = rr_pick(req_rd_valid, ptr_rd_q);
    rd_any     = (rd_state_q == ARB_LOCKED) | rd_pick[REQ_W];
    rd_g       = (rd_state_q == ARB_LOCKED) ? rd_grant_q : rd_pick[REQ_W-1:0];
    m_rd_valid = rd_any & req_rd_valid[rd_g] & ~tag_full;
    m_rd_pld   = rd_pld_arr[rd_g];
    req_rd_ready       = '0;
    req_rd_ready[rd_g] = m_rd_valid & m_rd_ready;
    rd_state_d = rd_state_q;
    ptr_rd_d   = ptr_rd_q;
    rd_grant_d = rd_grant_q;
    if (m_rd_valid && m_rd_ready) begin
      rd_state_d = ARB_IDLE;
      ptr_rd_d   = rr_next(rd_g);
    end else if (m_rd_valid) begin
      rd_state_d = ARB_LOCKED;
      rd_grant_d = rd_g;
    end
  end

  assign tag_push = m_rd_valid & m_rd_ready;
  assign tag_pop  = m_rvalid & (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({tag_push, tag_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    req_rvalid = '0;
    if (tag_pop) req_rvalid[tag_mem[tag_rd_ptr_q]] = 1'b1;
  end

  assign req_rdata      = m_rdata;
  assign rd_outstanding = count_q;
  assign err_orphan     = err_orphan_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state_q   <= ARB_IDLE;
      rd_state_q   <= ARB_IDLE;
      ptr_wr_q     <= '0;
      ptr_rd_q     <= '0;
      wr_grant_q   <= '0;
      rd_grant_q   <= '0;
      tag_wr_ptr_q <= '0;
      tag_rd_ptr_q <= '0;
      count_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      ptr_wr_q   <= ptr_wr_d;
      ptr_rd_q   <= ptr_rd_d;
      wr_grant_q <= wr_grant_d;
      rd_grant_q <= rd_grant_d;
      count_q    <= count_d;
      if (tag_push) tag_wr_ptr_q <= tag_wr_ptr_q + PTR_W'(1);
      if (tag_pop)  tag_rd_ptr_q <= tag_rd_ptr_q + PTR_W'(1);
      if (m_rvalid && (count_q == '0)) err_orphan_q <= 1'b1;
    end
  end

  // NOTE: tag storage has no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[tag_wr_ptr_q] <= rd_g;
  end

endmodule
